// File: rtl/prng_arbiter.sv
// Round-robin front end that time-shares one multi-cycle Lehmer PRNG core
// among N requesters, each with its own seed slot that advances on every result.
module prng_arbiter #(
  parameter int          N          = 4,
  parameter int          W          = 32,
  parameter int unsigned MOD        = 2147483647,
  parameter int unsigned MULT       = 16807,
  parameter int unsigned RESET_SEED = 1,
  parameter int          TIMEOUT    = 255,
  localparam int         IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  valid,
  output logic [W-1:0]  rand_out,
  output logic          err,
  input  logic          seed_we,
  input  logic [IW-1:0] seed_id,
  input  logic [W-1:0]  seed_data,
  output logic [W-1:0]  prng_m,
  output logic [W-1:0]  prng_a,
  output logic [W-1:0]  prng_seed,
  output logic          prng_start,
  output logic          prng_cont,
  input  logic          prng_done,
  input  logic [W-1:0]  prng_rand
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, START, RELEASE, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   ptr;
  logic [TW-1:0]   timer;
  logic [W-1:0]    result;
  logic            timed_out;
  logic            dirty;
  logic [W-1:0]    slot [N];

  logic            found;
  logic [IW-1:0]   pick;
  logic            seed_hit;
  logic [W-1:0]    seed_val;
  logic            timer_done;

  assign prng_m    = W'(MOD);
  assign prng_a    = W'(MULT);
  assign prng_cont = 1'b0;

  // Zero is a fixed point of the multiplicative generator, so it is never stored.
  assign seed_hit   = seed_we && (int'(seed_id) < N);
  assign seed_val   = (seed_data == '0) ? W'(1) : seed_data;
  assign timer_done = (timer == TW'(TIMEOUT));

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[IW'((int'(ptr) + i) % N)]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= '0;
      ptr        <= '0;
      timer      <= '0;
      result     <= '0;
      timed_out  <= 1'b0;
      dirty      <= 1'b0;
      valid      <= '0;
      err        <= 1'b0;
      rand_out   <= '0;
      prng_start <= 1'b0;
      prng_seed  <= '0;
      for (int i = 0; i < N; i++) slot[i] <= W'(RESET_SEED);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt        <= pick;
            prng_seed  <= slot[pick];
            prng_start <= 1'b1;
            timer      <= '0;
            timed_out  <= 1'b0;
            // A load landing on the grant edge must also beat the later write-back.
            dirty      <= seed_hit && (seed_id == pick);
            state      <= START;
          end
        end
        START: begin
          if (prng_done) begin
            result     <= prng_rand;
            prng_start <= 1'b0;
            timer      <= '0;
            state      <= RELEASE;
          end else if (timer_done) begin
            prng_start <= 1'b0;
            timed_out  <= 1'b1;
            valid      <= N'(1) << gnt;
            rand_out   <= '0;
            err        <= 1'b1;
            timer      <= '0;
            state      <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RELEASE: begin
          if (!prng_done) begin
            valid    <= N'(1) << gnt;
            rand_out <= result;
            err      <= 1'b0;
            timer    <= '0;
            state    <= RESP;
          end else if (timer_done) begin
            timed_out <= 1'b1;
            valid     <= N'(1) << gnt;
            rand_out  <= '0;
            err       <= 1'b1;
            timer     <= '0;
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          valid <= '0;
          err   <= 1'b0;
          if (!timed_out && !dirty) slot[gnt] <= result;
          ptr   <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
          timer <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a same-edge host load overrides the write-back.
      if (seed_hit) begin
        slot[seed_id] <= seed_val;
        if (state != IDLE && seed_id == gnt) dirty <= 1'b1;
      end
    end
  end

endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
Round-robin scheduler that shares one multi-cycle Lehmer prng core among N requesters. It keeps a private state (seed) register per requester, sequences the core's start/done handshake, and returns each result to its requester. It also writes each result back as that requester's next seed, so every requester sees an independent stream. The block sits between the client blocks and the single prng instance, and drives the core's m/a configuration.

Parameters:
N, 4, number of requesters (2..16)
W, 32, data width of seed/rand
MOD, 2147483647, modulus driven onto prng m
MULT, 16807, multiplier driven onto prng a
RESET_SEED, 1, per-slot seed value after reset
TIMEOUT, 255, max cycles waiting on any prng_done edge before abort

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req  in  N  per-requester request level; held until matching valid pulse
valid  out  N  one-hot, one-cycle pulse: rand_out is for this requester
rand_out  out  W  result, stable while valid high
err  out  1  one-cycle pulse with valid when the op timed out (rand_out = 0)
seed_we  in  1  load seed_data into slot seed_id
seed_id  in  clog2(N)  slot for seed load
seed_data  in  W  seed value
prng_m  out  W  constant MOD
prng_a  out  W  constant MULT
prng_seed  out  W  seed of the granted slot, held for whole op
prng_start  out  1  start to core
prng_cont  out  1  tied 0
prng_done  in  1  done from core
prng_rand  in  W  result from core

Behaviour:
- Reset (rst=0, async): state IDLE, valid=0, err=0, rand_out=0, prng_start=0, prng_seed=0, rr pointer=0, all seed slots=RESET_SEED, timer=0.
- FSM states:
  - IDLE: if any req, grant the first set bit searching cyclically from the pointer. Latch gnt id, drive prng_seed = slot[gnt], go START.
  - START: prng_start=1. On prng_done=1, capture prng_rand, drop start, go RELEASE.
  - RELEASE: prng_start=0. On prng_done=0, go RESP.
  - RESP: valid[gnt]=1 for one cycle, rand_out = captured value. Write the result back to slot[gnt]. Pointer = gnt+1 mod N. Go IDLE.
- Minimum latency req→valid = 3 cycles + core latency. No back-to-back grant: IDLE always lasts at least 1 cycle.
- Fairness: a requester with req held waits for at most N-1 other grants.
- Timer: cleared on each state entry and counts in START and RELEASE. If it reaches TIMEOUT, go to RESP with err=1, rand_out=0, no write-back, and prng_start forced 0.
- Seed load:
  - seed_we writes the slot in any state.
  - seed_data==0 is stored as 1, because 0 is a fixed point of the LCG.
  - If seed_we targets slot[gnt] while the op is in flight (START..RESP), that slot is marked dirty and the RESP write-back is suppressed; the load wins. The in-flight op still uses the old seed.
  - A seed load in the same cycle as RESP to the same slot also wins.
- req dropping mid-op: the op completes, the valid pulse is still issued, and the write-back still occurs.
- prng_done already high on entry to IDLE (core stale) is ignored; it is only sampled in START/RELEASE.
- A seed_id ≥ N is ignored.

Test Plan:
- Reset: all slots=1, req[0]=1 → prng_seed=1, valid[0] pulse, rand_out=16807. Second req[0] gives 282475249.
- Load seed 0x7B818935 into slot 2, req[2] → rand_out=0x755735EB; slot 2 now holds 0x755735EB.
- req=4'b1111 held → valid order 0,1,2,3,0. Each pulse is one cycle, one-hot, never two grants overlapping.
- Model the core stalling done=0 forever → after TIMEOUT cycles in START: err=1 pulse with valid[gnt], rand_out=0, slot unchanged, next requester served.
- seed_we to slot[gnt] with 0x00000000 during START → op returns the result of the old seed; slot afterwards reads 1 (request yields 16807).
- Assert rst=0 mid-RELEASE → outputs zero immediately (async), FSM IDLE, slots=RESET_SEED; no valid pulse after release.
